rggen_bus_arbiter: RTL

//  Shares one rggen native register bus (valid/access/address/write_data/strobe -> ready/status/read_data)

---
 rtl/rggen_bus_arbiter_pkg.sv | 9 +
 rtl/rggen_rr_arbiter_core.sv | 18 +
 rtl/rggen_bus_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/rggen_bus_arbiter_pkg.sv
// rggen_bus_arbiter_pkg: shared access codes, FSM states and width helper for the bus arbiter
package rggen_bus_arbiter_pkg;
  localparam logic [1:0] RGGEN_READ  = 2'b10;
  localparam logic [1:0] RGGEN_WRITE = 2'b11;
  typedef enum logic {IDLE, BUSY} arb_state_e;
  function automatic int clip_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rggen_rr_arbiter_core.sv
// rggen_rr_arbiter_core: one-hot winner = first valid searching upward from the pointer with wrap
module rggen_rr_arbiter_core #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_winner
);
  logic [N-1:0] rot;
  logic [N-1:0] lo;
  // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    rot      = N'({i_valid, i_valid} >> i_ptr);
    lo       = rot & (~rot + 1'b1);
    o_winner = N'(({lo, lo} << i_ptr) >> N);
  end
endmodule

// File: rtl/rggen_bus_arbiter.sv
// rggen_bus_arbiter: shares one rggen native register bus among several masters,
// round-robin or fixed priority, grant locked from first valid until ready.
module rggen_bus_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int REQUESTERS     = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [REQUESTERS-1:0]                i_bus_valid,
  input  logic [2*REQUESTERS-1:0]              i_bus_access,
  input  logic [ADDRESS_WIDTH*REQUESTERS-1:0]  i_bus_address,
  input  logic [BUS_WIDTH*REQUESTERS-1:0]      i_bus_write_data,
  input  logic [BUS_WIDTH/8*REQUESTERS-1:0]    i_bus_strobe,
  output logic [REQUESTERS-1:0]                o_bus_ready,
  output logic [2*REQUESTERS-1:0]              o_bus_status,
  output logic [BUS_WIDTH*REQUESTERS-1:0]      o_bus_read_data,
  output logic                                 o_bus_valid,
  output logic [1:0]                           o_bus_access,
  output logic [ADDRESS_WIDTH-1:0]             o_bus_address,
  output logic [BUS_WIDTH-1:0]                 o_bus_write_data,
  output logic [BUS_WIDTH/8-1:0]               o_bus_strobe,
  input  logic                                 i_bus_ready,
  input  logic [1:0]                           i_bus_status,
  input  logic [BUS_WIDTH-1:0]                 i_bus_read_data,
  output logic [REQUESTERS-1:0]                o_grant
);
  localparam int N  = REQUESTERS;
  localparam int PW = clip_clog2(N);
  localparam int AW = ADDRESS_WIDTH;
  localparam int BW = BUS_WIDTH;
  localparam int SW = BUS_WIDTH / 8;

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_next, sel_idx;
  logic [N-1:0]  grant_q, grant_d, winner, sel, act;

  rggen_rr_arbiter_core #(.N(N), .PW(PW)) u_core (
    .i_valid  (i_bus_valid),
    .i_ptr    (ptr_q),
    .o_winner (winner)
  );

  always_comb begin
    sel     = (state_q == BUSY) ? grant_q : winner;
    act     = i_rst ? '0 : (sel & i_bus_valid);
    sel_idx = '0;
    for (int i = 0; i < N; i++) if (sel[i]) sel_idx = PW'(i);
    ptr_next         = (FIXED_PRIORITY != 0 || sel_idx == PW'(N - 1)) ? '0 : sel_idx + 1'b1;
    o_grant          = act;
    o_bus_valid      = |act;
    o_bus_ready      = i_bus_ready ? act : '0;
    o_bus_access     = '0;
    o_bus_address    = '0;
    o_bus_write_data = '0;
    o_bus_strobe     = '0;
    o_bus_status     = '0;
    o_bus_read_data  = '0;
    for (int i = 0; i < N; i++) begin
      o_bus_access               |= {2{act[i]}} & i_bus_access[2*i+:2];
      o_bus_address              |= {AW{act[i]}} & i_bus_address[AW*i+:AW];
      o_bus_write_data           |= {BW{act[i]}} & i_bus_write_data[BW*i+:BW];
      o_bus_strobe               |= {SW{act[i]}} & i_bus_strobe[SW*i+:SW];
      o_bus_status[2*i+:2]        = act[i] ? i_bus_status : 2'b00;
      o_bus_read_data[BW*i+:BW]   = act[i] ? i_bus_read_data : '0;
    end
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    // A granted requester dropping valid releases the bus without moving the pointer.
    if (!o_bus_valid) begin
      state_d = IDLE;
      grant_d = '0;
    end else if (i_bus_ready) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d   = ptr_next;
    end else begin
      state_d = BUSY;
      grant_d = sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end
endmodule
